// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 scan timing: porch/sync widths, line/frame totals and sync polarity.
// Draw blocks reuse the visible limits; vga_scan_gen takes these as its parameter defaults.
package vga_timing_pkg;

  localparam int CNT_W     = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int CLK_DIV   = 4;
  localparam int PIPE_DLY  = 1;
  localparam bit SYNC_POL  = 1'b0;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } scan_flags_t;

  // Half-open window test [lo, hi) on 10-bit unsigned counters.
  function automatic logic in_window(cnt_t val, cnt_t lo, cnt_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Pixel-rate strobe: one-clk pix_tick every CLK_DIV clocks while en is high.
// Latency: first pix_tick CLK_DIV clocks after en rises; en low parks div at 0 on the next clk.
// No backpressure; free-running source.
module pix_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pix_tick
);

  localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);

  logic [3:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= 4'd0;
      pix_tick <= 1'b0;
    end else if (!en) begin
      div      <= 4'd0;
      pix_tick <= 1'b0;
    end else begin
      pix_tick <= (div == DIV_MAX);
      div      <= (div == DIV_MAX) ? 4'd0 : div + 4'd1;
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan source: h/v counters, visible flag and syncs, with flags delayed PIPE_DLY pixel ticks.
// Latency: counters move one clk after pix_tick; flags lag the counters by PIPE_DLY ticks.
// No backpressure; en low parks the scan at (0,0) with all flags inactive.
module vga_scan_gen #(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FP      = vga_timing_pkg::H_FP,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BP      = vga_timing_pkg::H_BP,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP      = vga_timing_pkg::V_FP,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BP      = vga_timing_pkg::V_BP,
  parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
  parameter int PIPE_DLY  = vga_timing_pkg::PIPE_DLY,
  parameter bit SYNC_POL  = vga_timing_pkg::SYNC_POL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pix_tick,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  import vga_timing_pkg::*;

  localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DEPTH = (PIPE_DLY == 0) ? 1 : PIPE_DLY;

  if (H_TOT > 1023 || V_TOT > 1023 || CLK_DIV < 1 || CLK_DIV > 16 ||
      PIPE_DLY < 0 || PIPE_DLY > 3) begin : g_param_check
    $error("vga_scan_gen: timing parameters out of range");
  end

  localparam cnt_t H_LAST = cnt_t'(H_TOT - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOT - 1);
  localparam cnt_t H_VIS  = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS  = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_LO  = cnt_t'(H_VISIBLE + H_FP);
  localparam cnt_t HS_HI  = cnt_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam cnt_t VS_LO  = cnt_t'(V_VISIBLE + V_FP);
  localparam cnt_t VS_HI  = cnt_t'(V_VISIBLE + V_FP + V_SYNC);

  pix_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .pix_tick (pix_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Both strobes mark the tick whose closing edge performs the wrap.
  assign line_start  = pix_tick && (h_cnt == H_LAST);
  assign frame_start = line_start && (v_cnt == V_LAST);

  scan_flags_t raw;

  always_comb begin
    raw     = '0;
    raw.vis = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    raw.hs  = in_window(h_cnt, HS_LO, HS_HI);
    raw.vs  = in_window(v_cnt, VS_LO, VS_HI);
  end

  // With no tick delay the flags still get one register stage, refreshed every clk.
  logic        advance;
  scan_flags_t pipe_q [DEPTH];

  assign advance = (PIPE_DLY == 0) || pix_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else if (!en) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else if (advance) begin
      pipe_q[0] <= raw;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign valid = pipe_q[DEPTH-1].vis;
  assign hsync = pipe_q[DEPTH-1].hs ? SYNC_POL : ~SYNC_POL;
  assign vsync = pipe_q[DEPTH-1].vs ? SYNC_POL : ~SYNC_POL;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench: default-timing instance plus two reduced-timing instances, checked every clk against a tick-count model.
module tb_vga_scan_gen;

  localparam int S_HV = 16, S_HFP = 2, S_HS = 3, S_HBP = 3;
  localparam int S_VV = 10, S_VFP = 1, S_VS = 2, S_VBP = 2;

  typedef struct packed {
    logic       pix;
    logic [9:0] h;
    logic [9:0] v;
    logic       valid;
    logic       hsync;
    logic       vsync;
    logic       ls;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, rst_s, en_s;

  logic       pix_a, valid_a, hs_a, vs_a, ls_a, fs_a;
  logic [9:0] h_a, v_a;
  logic       pix_b, valid_b, hs_b, vs_b, ls_b, fs_b;
  logic [9:0] h_b, v_b;
  logic       pix_c, valid_c, hs_c, vs_c, ls_c, fs_c;
  logic [9:0] h_c, v_c;

  vga_scan_gen dut_a (
    .clk(clk), .rst_n(rst_a), .en(en_a), .pix_tick(pix_a), .h_cnt(h_a), .v_cnt(v_a),
    .valid(valid_a), .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_scan_gen #(
    .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .CLK_DIV(3), .PIPE_DLY(2), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_s), .en(en_s), .pix_tick(pix_b), .h_cnt(h_b), .v_cnt(v_b),
    .valid(valid_b), .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b)
  );

  vga_scan_gen #(
    .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .CLK_DIV(1), .PIPE_DLY(0), .SYNC_POL(1'b0)
  ) dut_c (
    .clk(clk), .rst_n(rst_s), .en(en_s), .pix_tick(pix_c), .h_cnt(h_c), .v_cnt(v_c),
    .valid(valid_c), .hsync(hs_c), .vsync(vs_c), .line_start(ls_c), .frame_start(fs_c)
  );

  obs_t obs_a, obs_b, obs_c;
  assign obs_a = {pix_a, h_a, v_a, valid_a, hs_a, vs_a, ls_a, fs_a};
  assign obs_b = {pix_b, h_b, v_b, valid_b, hs_b, vs_b, ls_b, fs_b};
  assign obs_c = {pix_c, h_c, v_c, valid_c, hs_c, vs_c, ls_c, fs_c};

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  always @(posedge clk) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scan position (ticks consumed) after k enabled clocks since the last reset/park.
  function automatic int pos_at(int k, int d);
    return (k == 0) ? 0 : (k - 1) / d;
  endfunction

  function automatic obs_t model(int hv, int hfp, int hs, int hbp, int vv, int vfp, int vs, int vbp,
                                 int d, int p, bit pol, int k);
    int   ht, vt, n, src, sh, sv;
    obs_t o;
    ht     = hv + hfp + hs + hbp;
    vt     = vv + vfp + vs + vbp;
    n      = pos_at(k, d);
    o.pix  = (k >= 1) && (k % d == 0);
    o.h    = 10'(n % ht);
    o.v    = 10'((n / ht) % vt);
    o.ls   = o.pix && (n % ht == ht - 1);
    o.fs   = o.ls && ((n / ht) % vt == vt - 1);
    if (p == 0) src = (k == 0) ? -1 : pos_at(k - 1, d);
    else        src = n - p;
    if (src < 0) begin
      o.valid = 1'b0;
      o.hsync = ~pol;
      o.vsync = ~pol;
    end else begin
      sh      = src % ht;
      sv      = (src / ht) % vt;
      o.valid = (sh < hv) && (sv < vv);
      o.hsync = (sh >= hv + hfp && sh < hv + hfp + hs) ? pol : ~pol;
      o.vsync = (sv >= vv + vfp && sv < vv + vfp + vs) ? pol : ~pol;
    end
    return o;
  endfunction

  int k_a, k_s;

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a)     k_a <= 0;
    else if (!en_a) k_a <= 0;
    else            k_a <= k_a + 1;
  end

  always @(posedge clk or negedge rst_s) begin
    if (!rst_s)     k_s <= 0;
    else if (!en_s) k_s <= 0;
    else            k_s <= k_s + 1;
  end

  always @(negedge clk) begin
    if (cyc >= 2) begin
      check("scan_a", obs_a, model(640, 16, 96, 48, 480, 10, 2, 33, 4, 1, 1'b0, k_a));
      check("scan_b", obs_b, model(S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP, 3, 2, 1'b1, k_s));
      check("scan_c", obs_c, model(S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP, 1, 0, 1'b0, k_s));
    end
  end

  task automatic thread_default();
    int   n, t0, hs_low, vis, first_h;
    logic prev_hs;

    n = 0;
    do begin @(negedge clk); n++; end while (!pix_a && n < 20);
    check("first_tick_a", n, 4);
    n = 0;
    do begin @(negedge clk); n++; end while (!pix_a && n < 20);
    check("tick_period_a", n, 4);

    n = 0;
    do begin @(negedge clk); n++; end while (!ls_a && n < 4000);
    check("line_seen_a", ls_a, 1);
    t0 = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!ls_a && n < 4000);
    check("line_period_a", cyc - t0, 3200);

    hs_low = 0; vis = 0; first_h = -1; prev_hs = hs_a; n = 0;
    do begin
      @(negedge clk); n++;
      if (pix_a && !hs_a)   hs_low++;
      if (pix_a && valid_a) vis++;
      if (prev_hs && !hs_a && first_h < 0) first_h = h_a;
      prev_hs = hs_a;
    end while (!ls_a && n < 4000);
    check("hsync_ticks_a", hs_low, 96);
    check("valid_ticks_a", vis, 640);
    check("hsync_fall_h_a", first_h, 657);

    n = 0;
    do begin @(negedge clk); n++; end while (!(h_a == 10'd300 && v_a == 10'd3) && n < 8000);
    check("park_reach_a", {h_a, v_a}, {10'd300, 10'd3});
    en_a = 1'b0;
    repeat (10) @(negedge clk);
    check("park_a", obs_a, {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    en_a = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!pix_a && n < 20);
    check("restart_tick_a", n, 4);

    n = 0;
    do begin @(negedge clk); n++; end while (h_a != 10'd700 && n < 4000);
    check("pre_rst_hsync_a", {h_a, hs_a}, {10'd700, 1'b0});
    #2 rst_a = 1'b0;
    #1 check("async_rst_a", {h_a, v_a, hs_a, vs_a, valid_a}, {20'd0, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    rst_a = 1'b1;
    repeat (50) @(negedge clk);
  endtask

  task automatic thread_small();
    int n, t0;

    n = 0;
    do begin @(negedge clk); n++; end while (!fs_b && n < 3000);
    check("wrap_b", {fs_b, ls_b, h_b, v_b}, {1'b1, 1'b1, 10'd23, 10'd14});
    t0 = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!pix_b && n < 20);
    check("post_wrap_b", {h_b, v_b}, {10'd0, 10'd0});
    n = 0;
    do begin @(negedge clk); n++; end while (!fs_b && n < 3000);
    check("frame_period_b", cyc - t0, 1080);

    n = 0;
    do begin @(negedge clk); n++; end while (!fs_c && n < 1000);
    t0 = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!fs_c && n < 1000);
    check("frame_period_c", cyc - t0, 360);

    repeat (40) begin
      repeat ($urandom_range(600, 1)) @(negedge clk);
      if ($urandom_range(3, 0) == 0) begin
        rst_s = 1'b0;
        repeat ($urandom_range(3, 1)) @(negedge clk);
        rst_s = 1'b1;
      end else begin
        en_s = 1'b0;
        repeat ($urandom_range(20, 1)) @(negedge clk);
        en_s = 1'b1;
      end
    end
    repeat (1200) @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b0; en_a = 1'b1;
    rst_s = 1'b0; en_s = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_a", obs_a, {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    check("reset_b", obs_b, {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    rst_a = 1'b1;
    rst_s = 1'b1;
    fork
      thread_default();
      thread_small();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, compared=%0d", compared);
    $fatal(1, "timeout");
  end

endmodule
